// File: rtl/lockout_controller.sv
// lockout_controller
//   Watches the password-entry FSM and turns its activity into access
//   decisions. It counts failed attempts and drives a timed door-open pulse
//   after a successful entry. Repeated failures impose a timed lockout, and
//   repeated lockouts escalate to a sticky alarm that only a supervisor
//   clear removes. It also gates the FSM's confirm button.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   tick_en        single-cycle timebase strobe
//   status_in      one-hot password FSM state (bit0 idle, bits1-3 partial, bit4 admitted)
//   admitted_in    admitted flag from the password FSM
//   alarm_clr      single-cycle supervisor alarm clear
//   entry_enable   confirm button may reach the password FSM
//   door_open      door relay drive
//   locked         lockout (or alarm) active
//   alarm          sticky alarm
//   fail_count     failures since the last success or lockout
//   lock_remaining ticks left in a lockout, 0 otherwise
module lockout_controller #(
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned MAX_LOCKS  = 2,
  parameter int unsigned LOCK_TICKS = 20,
  parameter int unsigned OPEN_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic [4:0] status_in,
  input  logic       admitted_in,
  input  logic       alarm_clr,
  output logic       entry_enable,
  output logic       door_open,
  output logic       locked,
  output logic       alarm,
  output logic [2:0] fail_count,
  output logic [7:0] lock_remaining
);

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_OPEN,
    ST_LOCKED,
    ST_ALARM
  } state_t;

  localparam logic [2:0] FAIL_LAST  = 3'(MAX_TRIES - 1);
  localparam logic [1:0] LOCK_LIMIT = 2'(MAX_LOCKS);
  localparam logic [7:0] LOCK_LOAD  = 8'(LOCK_TICKS);
  localparam logic [7:0] OPEN_LOAD  = 8'(OPEN_TICKS);

  state_t     state_q, state_d;
  logic [4:0] prev_status_q;
  logic       prev_admitted_q;
  logic [2:0] fail_q, fail_d;
  logic [1:0] lock_q, lock_d;
  logic [7:0] timer_q, timer_d;

  logic prev_partial;
  logic fail_event;
  logic success_event;

  // A failure is a fall back to idle from a partial entry. Exact one-hot
  // matches reject any malformed status vector, and a wrong first digit
  // (idle staying idle) never registers.
  assign prev_partial  = (prev_status_q == 5'b00010) ||
                         (prev_status_q == 5'b00100) ||
                         (prev_status_q == 5'b01000);
  assign fail_event    = prev_partial && (status_in == 5'b00001);
  assign success_event = admitted_in && !prev_admitted_q;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_ARMED: begin
        // Success wins over a simultaneous failure.
        if (success_event) begin
          fail_d  = '0;
          lock_d  = '0;
          timer_d = OPEN_LOAD;
          state_d = ST_OPEN;
        end else if (fail_event) begin
          if (fail_q == FAIL_LAST) begin
            fail_d  = '0;
            lock_d  = lock_q + 2'd1;
            timer_d = LOCK_LOAD;
            state_d = (lock_d == LOCK_LIMIT) ? ST_ALARM : ST_LOCKED;
          end else begin
            fail_d = fail_q + 3'd1;
          end
        end
      end
      ST_OPEN, ST_LOCKED: begin
        // The timer bottoms out at 1; the expiring tick leaves the state
        // instead of decrementing.
        if (tick_en) begin
          if (timer_q == 8'd1) begin
            state_d = ST_ARMED;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      ST_ALARM: begin
        if (alarm_clr) begin
          state_d = ST_ARMED;
          lock_d  = '0;
          fail_d  = '0;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // Outputs are registered from the next-state values so each response
  // appears exactly one cycle after its event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_ARMED;
      prev_status_q   <= 5'b00001;
      prev_admitted_q <= 1'b0;
      fail_q          <= '0;
      lock_q          <= '0;
      timer_q         <= '0;
      entry_enable    <= 1'b1;
      door_open       <= 1'b0;
      locked          <= 1'b0;
      alarm           <= 1'b0;
      lock_remaining  <= '0;
    end else begin
      state_q         <= state_d;
      prev_status_q   <= status_in;
      prev_admitted_q <= admitted_in;
      fail_q          <= fail_d;
      lock_q          <= lock_d;
      timer_q         <= timer_d;
      entry_enable    <= (state_d == ST_ARMED);
      door_open       <= (state_d == ST_OPEN);
      locked          <= (state_d == ST_LOCKED) || (state_d == ST_ALARM);
      alarm           <= (state_d == ST_ALARM);
      lock_remaining  <= (state_d == ST_LOCKED) ? timer_d : '0;
    end
  end

  assign fail_count = fail_q;

endmodule

// File: tb/tb_lockout_controller.sv
module tb_lockout_controller;

  localparam int MAX_TRIES  = 3;
  localparam int MAX_LOCKS  = 2;
  localparam int LOCK_TICKS = 20;
  localparam int OPEN_TICKS = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic [4:0] status_in = 5'b00001;
  logic       admitted_in = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       entry_enable, door_open, locked, alarm;
  logic [2:0] fail_count;
  logic [7:0] lock_remaining;

  lockout_controller #(
    .MAX_TRIES (MAX_TRIES),
    .MAX_LOCKS (MAX_LOCKS),
    .LOCK_TICKS(LOCK_TICKS),
    .OPEN_TICKS(OPEN_TICKS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_en       (tick_en),
    .status_in     (status_in),
    .admitted_in   (admitted_in),
    .alarm_clr     (alarm_clr),
    .entry_enable  (entry_enable),
    .door_open     (door_open),
    .locked        (locked),
    .alarm         (alarm),
    .fail_count    (fail_count),
    .lock_remaining(lock_remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ee;
    logic       door;
    logic       lk;
    logic       al;
    logic [2:0] fc;
    logic [7:0] lr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: access mode plus plain integer counters.
  localparam int MODE_ARMED  = 0;
  localparam int MODE_OPEN   = 1;
  localparam int MODE_LOCKED = 2;
  localparam int MODE_ALARM  = 3;
  int         m_mode  = MODE_ARMED;
  int         m_fails = 0;
  int         m_locks = 0;
  int         m_left  = 0;
  logic [4:0] m_prev  = 5'b00001;
  logic       m_prev_adm = 1'b0;

  task automatic model(input logic r, input logic t, input logic [4:0] s,
                       input logic a, input logic c);
    bit fail, succ;
    exp_t e;
    if (r) begin
      m_mode = MODE_ARMED; m_fails = 0; m_locks = 0; m_left = 0;
      m_prev = 5'b00001; m_prev_adm = 1'b0;
    end else begin
      fail = ($countones(m_prev) == 1) && (m_prev[1] || m_prev[2] || m_prev[3])
             && (s == 5'b00001);
      succ = a && !m_prev_adm;
      case (m_mode)
        MODE_ARMED:
          if (succ) begin
            m_fails = 0; m_locks = 0; m_left = OPEN_TICKS; m_mode = MODE_OPEN;
          end else if (fail) begin
            if (m_fails + 1 == MAX_TRIES) begin
              m_fails = 0; m_locks++; m_left = LOCK_TICKS;
              m_mode = (m_locks == MAX_LOCKS) ? MODE_ALARM : MODE_LOCKED;
            end else begin
              m_fails++;
            end
          end
        MODE_OPEN, MODE_LOCKED:
          if (t) begin
            if (m_left == 1) m_mode = MODE_ARMED;
            else m_left--;
          end
        default:
          if (c) begin
            m_mode = MODE_ARMED; m_locks = 0; m_fails = 0;
          end
      endcase
      m_prev = s;
      m_prev_adm = a;
    end
    e.ee   = (m_mode == MODE_ARMED);
    e.door = (m_mode == MODE_OPEN);
    e.lk   = (m_mode == MODE_LOCKED) || (m_mode == MODE_ALARM);
    e.al   = (m_mode == MODE_ALARM);
    e.fc   = 3'(m_fails);
    e.lr   = (m_mode == MODE_LOCKED) ? 8'(m_left) : 8'd0;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input logic r, input logic t, input logic [4:0] s,
                      input logic a, input logic c);
    @(negedge clk);
    rst = r; tick_en = t; status_in = s; admitted_in = a; alarm_clr = c;
    model(r, t, s, a, c);
  endtask

  task automatic idle(input int n, input logic t);
    for (int i = 0; i < n; i++) step(1'b0, t, 5'b00001, 1'b0, 1'b0);
  endtask

  task automatic fail_once();
    step(1'b0, 1'b0, 5'b00010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("entry_enable",   8'(entry_enable), 8'(e.ee));
        check("door_open",      8'(door_open),    8'(e.door));
        check("locked",         8'(locked),       8'(e.lk));
        check("alarm",          8'(alarm),        8'(e.al));
        check("fail_count",     8'(fail_count),   8'(e.fc));
        check("lock_remaining", lock_remaining,   e.lr);
      end
    end
  end

  initial begin
    logic       adm_r;
    logic [4:0] s;
    int         k;
    // 1: reset
    step(1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
    idle(2, 1'b0);
    // wrong first digit: idle stays idle, not a failure
    idle(3, 1'b0);
    // 2: three failures -> lockout, then expire it
    fail_once(); fail_once(); fail_once();
    idle(2, 1'b0);
    idle(LOCK_TICKS, 1'b1);
    idle(2, 1'b0);
    // 3: full entry with admitted edge, second edge while open
    step(1'b0, 1'b0, 5'b00010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b00100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b01000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'b10000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'b10000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'b10000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'b10000, 1'b1, 1'b0);
    idle(6, 1'b1);
    // 4: two lockouts -> alarm, ticks ignored, clear
    for (int i = 0; i < MAX_TRIES; i++) fail_once();
    idle(LOCK_TICKS, 1'b1);
    for (int i = 0; i < MAX_TRIES; i++) fail_once();
    idle(100, 1'b1);
    step(1'b0, 1'b0, 5'b00001, 1'b0, 1'b1);
    idle(2, 1'b0);
    // 5: failure and admitted edge together; non-one-hot status
    step(1'b0, 1'b0, 5'b00010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b00001, 1'b1, 1'b0);
    idle(OPEN_TICKS + 1, 1'b1);
    step(1'b0, 1'b0, 5'b00110, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
    fail_once();
    // alarm_clr outside ALARM has no effect
    step(1'b0, 1'b0, 5'b00001, 1'b0, 1'b1);
    // 6: reset mid-lockout with 7 ticks remaining
    fail_once(); fail_once();
    idle(LOCK_TICKS - 7, 1'b1);
    step(1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
    idle(2, 1'b0);
    // randomized traffic
    adm_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 6);
      if (k < 5) s = 5'b00001 << k;
      else if (k == 5) s = 5'b00001;
      else s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) adm_r = ~adm_r;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), s, adm_r,
           ($urandom_range(0, 9) == 0));
    end
    @(negedge clk);
    rst = 1'b0; tick_en = 1'b0; alarm_clr = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lockout_controller.md
Name: lockout_controller

Overview:
- Downstream consumer of the password-entry FSM: watches its one-hot status vector and admitted flag.
- Counts failed attempts, drives a timed door-open output on success, and imposes a timed lockout after repeated failures.
- Escalates to a sticky alarm after repeated lockouts.
- Gates the FSM's confirm button through entry_enable.

Parameters:
MAX_TRIES, 3, failed attempts that trigger a lockout (1..7)
MAX_LOCKS, 2, consecutive lockouts that trigger the alarm (1..3)
LOCK_TICKS, 20, lockout duration in tick_en strobes (1..255)
OPEN_TICKS, 5, door-open duration in tick_en strobes (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_en  in  1  single-cycle timebase strobe from the clock divider
status_in  in  5  one-hot state of the password FSM (bit0 = idle, bits1-3 = partial entry, bit4 = admitted)
admitted_in  in  1  admitted flag from the password FSM
alarm_clr  in  1  single-cycle supervisor clear of the alarm
entry_enable  out  1  1 = confirm button may reach the password FSM
door_open  out  1  door relay drive
locked  out  1  lockout active
alarm  out  1  sticky alarm
fail_count  out  3  failures since the last success or lockout
lock_remaining  out  8  ticks left in the lockout, 0 outside LOCKED

Behaviour:
- Reset, synchronous, takes effect at the clk edge while rst=1:
  - state=ARMED; all counters 0; prev_status=5'b00001.
  - entry_enable=1; door_open=0; locked=0; alarm=0; fail_count=0; lock_remaining=0.
- prev_status registers status_in every cycle.
- Failure event: prev_status is one-hot in bit1, bit2 or bit3 AND status_in==5'b00001.
  - A wrong first digit, where the FSM stays idle, is not counted. This is decided.
- Success event: admitted_in=1 AND the registered previous admitted_in=0 (rising edge).
- A status_in that is not one-hot generates no event.
- All outputs are registered; every response appears the cycle after the event cycle.
- Success has priority over failure in the same cycle.
- States:
  - ARMED:
    - entry_enable=1.
    - On success: fail_count←0, lock_count←0, timer←OPEN_TICKS, go to OPEN.
    - On failure with fail_count==MAX_TRIES-1: fail_count←0, lock_count←lock_count+1, timer←LOCK_TICKS. Go to ALARM if the new lock_count==MAX_LOCKS, else go to LOCKED.
    - On any other failure: fail_count←fail_count+1.
  - OPEN:
    - door_open=1, entry_enable=0.
    - On each tick_en: timer←timer-1.
    - tick_en with timer==1 → ARMED.
    - Further events are ignored.
  - LOCKED:
    - locked=1, entry_enable=0, lock_remaining=timer.
    - Decrements on tick_en.
    - tick_en with timer==1 → ARMED, lock_remaining←0.
    - Events are ignored; lock_count is retained.
  - ALARM:
    - alarm=1, locked=1, entry_enable=0, lock_remaining=0.
    - Timer is ignored.
    - alarm_clr=1 → ARMED with lock_count←0, fail_count←0.
- alarm_clr outside ALARM has no effect.
- lock_count clears only on success or alarm_clr; it does not clear when a lockout expires.
- tick_en arriving in the same cycle as state entry does not decrement the freshly loaded timer.
- rst in any state, including mid-lockout and ALARM, forces the reset values on the next edge.
- Timer width is 8 bits with no wrap: it never decrements below 1 inside OPEN or LOCKED.

Test Plan:
1. Reset with rst=1 for 2 cycles → entry_enable=1, every other output 0, fail_count=0.
2. Three sequences of status 00010→00001 (MAX_TRIES=3) → fail_count counts 1, 2, then locked=1 with lock_remaining=20. Then 20 tick_en → locked=0, ARMED, fail_count=0.
3. Status 00001→00010→00100→01000→10000 with admitted_in rising → door_open=1 for exactly 5 tick_en, fail_count=0. A second admitted edge while OPEN does not extend the open time.
4. Two full lockouts with no success in between → after the 6th failure alarm=1, locked=1. 100 tick_en leave it unchanged. alarm_clr pulse → ARMED, alarm=0.
5. Failure and admitted rising edge in the same cycle → OPEN is entered and fail_count stays 0. A non-one-hot status_in of 00110 generates no event.
6. rst asserted with lock_remaining=7 → next cycle locked=0, lock_remaining=0, entry_enable=1.
